// File: rtl/sound_pkg.sv
// Shared constants and helpers for the sound channels: divider base, envelope
// volume limits, LFSR freeze threshold and the default length-counter width.
package sound_pkg;

  localparam int         DIV_BASE_DEF  = 8;
  localparam int         LEN_WIDTH_DEF = 6;
  localparam logic [3:0] VOL_MIN       = 4'd0;
  localparam logic [3:0] VOL_MAX       = 4'd15;
  localparam logic [3:0] SHIFT_FREEZE  = 4'd14;

  // Unshifted divider length in clocks: base for code 0, otherwise 2*base*code.
  function automatic logic [31:0] divisorClocks(input logic [2:0] code, input int base);
    if (code == 3'd0) return 32'(base);
    return 32'(2 * base * int'(code));
  endfunction

endpackage

// File: rtl/sound_noise_lfsr.sv
// Noise LFSR: XOR of the two low bits shifts in at the top, and in short mode
// it is also written into SHORT_TAP to give a 127-step sequence.
module sound_noise_lfsr #(
  parameter int LFSR_WIDTH = 15,
  parameter int SHORT_TAP  = 6
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  step,
  input  logic                  load_ones,
  input  logic                  short_mode,
  output logic [LFSR_WIDTH-1:0] lfsr_q
);

  logic                  fb;
  logic [LFSR_WIDTH-1:0] shifted;

  always_comb begin
    fb      = lfsr_q[0] ^ lfsr_q[1];
    shifted = {fb, lfsr_q[LFSR_WIDTH-1:1]};
    if (short_mode) shifted[SHORT_TAP] = fb;
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset)        lfsr_q <= '1;
    else if (load_ones) lfsr_q <= '1;
    else if (step)      lfsr_q <= shifted;
  end

endmodule

// File: rtl/sound_ch4_noise_gen.sv
// Channel-4 noise generator: programmable divider clocking the noise LFSR,
// volume envelope, length counter and channel-active flag feeding the mixer.
module sound_ch4_noise_gen
  import sound_pkg::*;
#(
  parameter int LFSR_WIDTH  = 15,
  parameter int SHORT_TAP   = 6,
  parameter int DIV_BASE    = DIV_BASE_DEF,
  parameter int TIMER_WIDTH = 20,
  parameter int LEN_WIDTH   = LEN_WIDTH_DEF
) (
  input  logic                 iClock,
  input  logic                 iReset,
  input  logic                 iTrigger,
  input  logic [2:0]           iDivCode,
  input  logic [3:0]           iShift,
  input  logic                 iShortMode,
  input  logic [3:0]           iEnvInitial,
  input  logic                 iEnvIncrease,
  input  logic [2:0]           iEnvPeriod,
  input  logic [LEN_WIDTH-1:0] iLengthLoad,
  input  logic                 iLengthLoadStrobe,
  input  logic                 iLengthEnable,
  input  logic                 iLengthTick,
  input  logic                 iEnvTick,
  output logic [3:0]           oOut,
  output logic                 oActive
);

  localparam logic [LEN_WIDTH:0] LEN_MAX = {1'b1, {LEN_WIDTH{1'b0}}};
  localparam logic [LEN_WIDTH:0] LEN_ONE = {{LEN_WIDTH{1'b0}}, 1'b1};

  logic [LFSR_WIDTH-1:0]  lfsrQ;
  logic [TIMER_WIDTH-1:0] timer;
  logic [3:0]             volume;
  logic [2:0]             envCnt;
  logic [LEN_WIDTH:0]     lenCnt;
  logic                   active;

  logic [31:0]            periodFull;
  logic [TIMER_WIDTH-1:0] timerReload;
  logic                   frozen;
  logic                   lfsrStep;
  logic                   lfsrLoad;
  logic                   dacOff;
  logic [LEN_WIDTH:0]     lenLoaded;
  logic                   lenExpire;
  logic                   envTickEn;

  function automatic logic [3:0] volStep(input logic [3:0] v, input logic up);
    if (up) return (v == VOL_MAX) ? VOL_MAX : v + 4'd1;
    return (v == VOL_MIN) ? VOL_MIN : v - 4'd1;
  endfunction

  always_comb begin
    periodFull  = divisorClocks(iDivCode, DIV_BASE) << iShift;
    timerReload = TIMER_WIDTH'(periodFull - 32'd1);
    frozen      = (iShift >= SHIFT_FREEZE);
    lfsrStep    = !iTrigger && !frozen && (timer == '0);
    // An all-zero register would lock up; reseed it rather than stay silent.
    lfsrLoad    = iTrigger || (lfsrQ == '0);
    dacOff      = (iEnvInitial == 4'd0) && !iEnvIncrease;
    lenLoaded   = iLengthLoadStrobe ? (LEN_MAX - {1'b0, iLengthLoad}) : lenCnt;
    lenExpire   = !iTrigger && !iLengthLoadStrobe && iLengthTick && iLengthEnable &&
                  (lenCnt == LEN_ONE);
    envTickEn   = !iTrigger && iEnvTick && (iEnvPeriod != 3'd0) && active;
  end

  sound_noise_lfsr #(
    .LFSR_WIDTH (LFSR_WIDTH),
    .SHORT_TAP  (SHORT_TAP)
  ) uLfsr (
    .iClock     (iClock),
    .iReset     (iReset),
    .step       (lfsrStep),
    .load_ones  (lfsrLoad),
    .short_mode (iShortMode),
    .lfsr_q     (lfsrQ)
  );

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset)                timer <= '0;
    else if (iTrigger)          timer <= timerReload;
    else if (!frozen) begin
      if (timer == '0)          timer <= timerReload;
      else                      timer <= timer - TIMER_WIDTH'(1);
    end
  end

  // The load is applied before the trigger's empty-counter check.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset)                lenCnt <= '0;
    else if (iTrigger)          lenCnt <= (lenLoaded == '0) ? LEN_MAX : lenLoaded;
    else if (iLengthLoadStrobe) lenCnt <= lenLoaded;
    else if (iLengthTick && iLengthEnable && (lenCnt != '0))
                                lenCnt <= lenCnt - LEN_ONE;
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      volume <= VOL_MIN;
      envCnt <= 3'd0;
    end else if (iTrigger) begin
      volume <= iEnvInitial;
      envCnt <= iEnvPeriod;
    end else if (envTickEn) begin
      if (envCnt <= 3'd1) begin
        envCnt <= iEnvPeriod;
        volume <= volStep(volume, iEnvIncrease);
      end else begin
        envCnt <= envCnt - 3'd1;
      end
    end
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset)                 active <= 1'b0;
    else if (iTrigger)           active <= !dacOff;
    else if (dacOff || lenExpire) active <= 1'b0;
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) oOut <= 4'd0;
    else         oOut <= (active && !lfsrQ[0]) ? volume : 4'd0;
  end

  assign oActive = active;

endmodule

// File: tb/tb_sound_ch4_noise_gen.sv
// Directed bench for the channel-4 noise generator with hand-computed values.
module tb_sound_ch4_noise_gen;

  logic       iClock = 1'b0;
  logic       iReset;
  logic       iTrigger;
  logic [2:0] iDivCode;
  logic [3:0] iShift;
  logic       iShortMode;
  logic [3:0] iEnvInitial;
  logic       iEnvIncrease;
  logic [2:0] iEnvPeriod;
  logic [5:0] iLengthLoad;
  logic       iLengthLoadStrobe;
  logic       iLengthEnable;
  logic       iLengthTick;
  logic       iEnvTick;
  logic [3:0] oOut;
  logic       oActive;

  int checks = 0;
  int errors = 0;

  sound_ch4_noise_gen dut (
    .iClock            (iClock),
    .iReset            (iReset),
    .iTrigger          (iTrigger),
    .iDivCode          (iDivCode),
    .iShift            (iShift),
    .iShortMode        (iShortMode),
    .iEnvInitial       (iEnvInitial),
    .iEnvIncrease      (iEnvIncrease),
    .iEnvPeriod        (iEnvPeriod),
    .iLengthLoad       (iLengthLoad),
    .iLengthLoadStrobe (iLengthLoadStrobe),
    .iLengthEnable     (iLengthEnable),
    .iLengthTick       (iLengthTick),
    .iEnvTick          (iEnvTick),
    .oOut              (oOut),
    .oActive           (oActive)
  );

  always #5 iClock = ~iClock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic trigger();
    iTrigger = 1'b1;
    tick();
    iTrigger = 1'b0;
  endtask

  task automatic envPulse();
    iEnvTick = 1'b1;
    tick();
    iEnvTick = 1'b0;
  endtask

  task automatic lenPulse();
    iLengthTick = 1'b1;
    tick();
    iLengthTick = 1'b0;
  endtask

  logic [3:0] envUp [6];

  initial begin
    envUp = '{4'd14, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
    iReset = 1'b0; iTrigger = 1'b0; iDivCode = 3'd0; iShift = 4'd0;
    iShortMode = 1'b0; iEnvInitial = 4'd15; iEnvIncrease = 1'b0; iEnvPeriod = 3'd0;
    iLengthLoad = 6'd0; iLengthLoadStrobe = 1'b0; iLengthEnable = 1'b0;
    iLengthTick = 1'b0; iEnvTick = 1'b0;
    ticks(2);
    check("rst_out", oOut, 4'd0);
    check("rst_active", oActive, 1'b0);
    check("rst_lfsr", dut.lfsrQ, 15'h7FFF);
    iReset = 1'b1;
    tick();

    // Long mode, P = 8
    trigger();
    check("a_lfsr0", dut.lfsrQ, 15'h7FFF);
    check("a_active", oActive, 1'b1);
    ticks(7);
    check("a_lfsr_hold", dut.lfsrQ, 15'h7FFF);
    tick();
    check("a_lfsr1", dut.lfsrQ, 15'h3FFF);
    ticks(8);
    check("a_lfsr2", dut.lfsrQ, 15'h1FFF);
    check("a_out_quiet", oOut, 4'd0);
    ticks(104);
    check("a_lfsr15", dut.lfsrQ, 15'h4000);
    check("a_out_lag", oOut, 4'd0);
    tick();
    check("a_out_on", oOut, 4'd15);

    // Short mode, P = 16 << 2 = 64
    iShortMode = 1'b1; iDivCode = 3'd1; iShift = 4'd2;
    trigger();
    ticks(63);
    check("b_hold", dut.lfsrQ, 15'h7FFF);
    tick();
    check("b_step1", dut.lfsrQ, 15'h3FBF);
    ticks(127 * 64);
    check("b_period", dut.lfsrQ, 15'h3FBF);
    check("b_active", oActive, 1'b1);

    // Frozen shift
    iShortMode = 1'b0; iDivCode = 3'd0; iShift = 4'd14;
    trigger();
    ticks(10000);
    check("c_frozen", dut.lfsrQ, 15'h7FFF);
    check("c_out", oOut, 4'd0);

    // Length expiry
    iShift = 4'd0; iLengthLoad = 6'd62; iLengthEnable = 1'b1;
    iLengthLoadStrobe = 1'b1; tick(); iLengthLoadStrobe = 1'b0;
    trigger();
    ticks(121);
    check("d_out_on", oOut, 4'd15);
    lenPulse();
    check("d_active1", oActive, 1'b1);
    lenPulse();
    check("d_active2", oActive, 1'b0);
    check("d_out_lag", oOut, 4'd15);
    tick();
    check("d_out_off", oOut, 4'd0);

    // Length disabled
    iLengthEnable = 1'b0;
    iLengthLoadStrobe = 1'b1; tick(); iLengthLoadStrobe = 1'b0;
    trigger();
    ticks(121);
    lenPulse();
    lenPulse();
    tick();
    check("e_active", oActive, 1'b1);
    check("e_out", oOut, 4'd15);

    // Load together with trigger: counter becomes 64-63 = 1
    iLengthEnable = 1'b1; iLengthLoad = 6'd63;
    iLengthLoadStrobe = 1'b1; trigger(); iLengthLoadStrobe = 1'b0;
    check("f_active", oActive, 1'b1);
    lenPulse();
    check("f_expire", oActive, 1'b0);
    iLengthEnable = 1'b0;

    // Envelope down with saturation
    iEnvInitial = 4'd2; iEnvIncrease = 1'b0; iEnvPeriod = 3'd1;
    trigger();
    check("g_vol0", dut.volume, 4'd2);
    envPulse();
    check("g_vol1", dut.volume, 4'd1);
    envPulse();
    check("g_vol2", dut.volume, 4'd0);
    envPulse();
    check("g_vol3", dut.volume, 4'd0);

    // Envelope up, period 2
    iEnvInitial = 4'd14; iEnvIncrease = 1'b1; iEnvPeriod = 3'd2;
    trigger();
    for (int i = 0; i < 6; i++) begin
      envPulse();
      check("h_vol", dut.volume, envUp[i]);
    end

    // Trigger beats envelope tick
    iEnvInitial = 4'd9; iEnvIncrease = 1'b0; iEnvPeriod = 3'd1;
    iEnvTick = 1'b1; trigger(); iEnvTick = 1'b0;
    check("i_vol_trig", dut.volume, 4'd9);
    envPulse();
    check("i_vol_dec", dut.volume, 4'd8);

    // DAC off
    iEnvInitial = 4'd0; iEnvIncrease = 1'b0;
    tick();
    check("j_dac_off", oActive, 1'b0);
    trigger();
    check("j_trig_off", oActive, 1'b0);

    // Asynchronous reset mid-run
    iEnvInitial = 4'd15; iEnvPeriod = 3'd0;
    trigger();
    ticks(121);
    check("k_out_on", oOut, 4'd15);
    iReset = 1'b0;
    #2;
    check("k_rst_out", oOut, 4'd0);
    check("k_rst_active", oActive, 1'b0);
    #1;
    iReset = 1'b1;
    #1;
    check("k_rst_lfsr", dut.lfsrQ, 15'h7FFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sound_ch4_noise_gen.md
Name: sound_ch4_noise_gen

Overview:
- Parametrised successor of the channel-4 white-noise source.
- Adds a programmable clock divider (divisor code plus shift), a selectable long or short LFSR width, a volume envelope, a length counter, trigger/restart and a channel-active flag.
- Sits between the sound register file, which drives its control inputs, and the channel mixer, which consumes the 4-bit amplitude.
- Frame-sequencer ticks come from the shared sound timing block as 1-cycle strobes.

Parameters:
- LFSR_WIDTH, 15: total LFSR length in bits.
- SHORT_TAP, 6: bit index that also receives feedback in short mode.
- DIV_BASE, 8: clock count for divisor code 0; code r>0 gives 2*DIV_BASE*r.
- TIMER_WIDTH, 20: width of the divider down-counter; must hold (14*DIV_BASE)<<13.
- LEN_WIDTH, 6: width of the length counter; maximum length is 2^LEN_WIDTH.

Ports:
- iClock  in  1  system clock.
- iReset  in  1  asynchronous, active-low reset.
- iTrigger  in  1  1-cycle restart strobe.
- iDivCode  in  3  divisor code r.
- iShift  in  4  clock shift s; values 14 and 15 freeze the LFSR.
- iShortMode  in  1  1 = short mode (feedback also into SHORT_TAP).
- iEnvInitial  in  4  initial volume.
- iEnvIncrease  in  1  1 = envelope counts up, 0 = down.
- iEnvPeriod  in  3  envelope period in iEnvTick units; 0 disables the envelope.
- iLengthLoad  in  LEN_WIDTH  length data.
- iLengthLoadStrobe  in  1  loads the length counter.
- iLengthEnable  in  1  length counter stops the channel when enabled.
- iLengthTick  in  1  256 Hz strobe.
- iEnvTick  in  1  64 Hz strobe.
- oOut  out  4  amplitude to the mixer.
- oActive  out  1  channel running.

Behaviour:
- Reset (iReset=0, asynchronous):
  - LFSR = all ones; timer = 0; volume = 0; envelope counter = 0; length counter = 0.
  - oActive = 0; oOut = 0.
- Divider period P:
  - P = (r==0 ? DIV_BASE : 2*DIV_BASE*r) << s.
  - The timer counts down once per clock. At timer==0 it reloads P-1 and the LFSR steps, so there is one step every P clocks.
  - If s >= 14 the timer and LFSR hold their values.
- LFSR step:
  - fb = lfsr[0] XOR lfsr[1].
  - lfsr = {fb, lfsr[LFSR_WIDTH-1:1]}.
  - If iShortMode=1, bit SHORT_TAP is also overwritten with fb after the shift.
- Trigger, taking effect in the cycle after the strobe:
  - LFSR = all ones; timer = P-1; volume = iEnvInitial; envelope counter = iEnvPeriod.
  - If the length counter is 0, it loads 2^LEN_WIDTH.
  - oActive = 1, unless the DAC is off (iEnvInitial==0 and iEnvIncrease==0), in which case oActive = 0.
- DAC off at any time: oActive is cleared the next cycle.
- Length:
  - iLengthLoadStrobe: counter = 2^LEN_WIDTH - iLengthLoad.
  - iLengthTick with iLengthEnable=1 and counter>0: counter decrements. When it reaches 0, oActive clears the same cycle.
  - Counter at 0 with a tick: no change.
- Envelope, on iEnvTick when iEnvPeriod != 0 and oActive=1:
  - The envelope counter decrements.
  - On reaching 0 it reloads iEnvPeriod, and volume moves by +1 or -1 saturating at 15 or 0. At the limit the volume holds with no wrap.
  - iEnvPeriod==0: volume is frozen.
- Output:
  - oOut is registered: oOut <= (oActive && lfsr[0]==0) ? volume : 0.
  - 1-cycle latency from any LFSR, volume or active change.
- Simultaneous events:
  - Trigger beats iLengthTick, iEnvTick and an LFSR step in the same cycle.
  - iLengthLoadStrobe beats iLengthTick.
  - Trigger together with iLengthLoadStrobe: the load applies first, then the 0→max rule is evaluated on the loaded value.
- Control changes (iDivCode, iShift) mid-count do not alter the current timer count; the new P applies at the next reload.
- Reset asserted mid-operation returns every register to its reset value immediately.

Decomposition:
- Shared package sound_pkg holds:
  - DIV_BASE default and the divisor-code function.
  - The envelope volume limits (0 and 15).
  - The frozen-shift threshold (14).
  - LEN_WIDTH default.
- One sub-module: sound_noise_lfsr.
  - Parametrised by LFSR_WIDTH and SHORT_TAP.
  - Ports: step, load_ones, short_mode, lfsr_q.
- The divider, envelope and length logic stay in the top level.

Test Plan:
- Trigger with r=0, s=0, iEnvInitial=15, long mode:
  - The LFSR steps every 8 clocks: 0x7FFF → 0x3FFF → 0x1FFF.
  - oOut stays 0 while lfsr[0]=1, and becomes 15 once the first 0 reaches bit0 (after 15 steps).
- Short mode, r=1, s=2, from 0x7FFF:
  - The first step occurs 64 clocks after the trigger, giving 0x3FBF.
  - The sequence has period 127 steps.
- s=14: after trigger the LFSR holds 0x7FFF for 10000 clocks and oOut stays 0.
- Length:
  - iLengthLoad=62 with iLengthEnable=1, trigger, then 2 iLengthTick: oActive falls on the 2nd tick and oOut is 0 the next cycle.
  - Repeat with iLengthEnable=0: oActive stays 1.
- Envelope:
  - iEnvInitial=2, decrease, period=1, 3 iEnvTick: volume goes 1, 0, 0 (saturates).
  - iEnvInitial=14, increase, period=2, 6 ticks: volume goes 15 and holds.
- Collisions and reset:
  - Trigger and iEnvTick in the same cycle: volume equals iEnvInitial, with no decrement.
  - iReset pulsed low mid-run: oOut=0 and oActive=0 asynchronously, and the LFSR reads 0x7FFF after release.
